// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, fetch FSM states and the NOP word.
package cpu_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT  = 2'b00,
    WAIT  = 2'b01,
    READY = 2'b10
  } fetch_state_e;

endpackage

// File: rtl/fetch_redirect_sel.sv
// Redirect arbitration for the fetch stage: csr_redirect beats branch_taken,
// and a redirect that arrives while the held instruction cannot advance is
// parked in pend/pend_tgt until the next advance.
module fetch_redirect_sel
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            i_soft_rst,
  input  logic            i_csr_redirect,
  input  logic [XLEN-1:0] i_csr_target,
  input  logic            i_branch_taken,
  input  logic [XLEN-1:0] i_branch_target,
  input  logic            i_set_pend,
  input  logic            i_clr_pend,
  output logic            o_redirect,
  output logic [XLEN-1:0] o_redir_tgt,
  output logic            o_take,
  output logic [XLEN-1:0] o_take_tgt
);

  logic            r_pend;
  logic [XLEN-1:0] r_pend_tgt;
  logic            w_redirect;
  logic [XLEN-1:0] w_redir_tgt;

  // Priority select; a live redirect is newer than any parked one.
  always_comb begin
    w_redirect  = i_csr_redirect | i_branch_taken;
    w_redir_tgt = i_branch_target;
    if (i_csr_redirect) begin
      w_redir_tgt = i_csr_target;
    end else begin
      w_redir_tgt = i_branch_target;
    end
    o_redirect  = w_redirect;
    o_redir_tgt = w_redir_tgt;
    o_take      = w_redirect | r_pend;
    if (w_redirect) begin
      o_take_tgt = w_redir_tgt;
    end else begin
      o_take_tgt = r_pend_tgt;
    end
  end

  // Parked redirect; a later redirect overwrites the parked target.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pend     <= 1'b0;
      r_pend_tgt <= {XLEN{1'b0}};
    end else if (i_soft_rst) begin
      r_pend     <= 1'b0;
      r_pend_tgt <= {XLEN{1'b0}};
    end else if (i_set_pend) begin
      r_pend     <= 1'b1;
      r_pend_tgt <= w_redir_tgt;
    end else if (i_clr_pend) begin
      r_pend     <= 1'b0;
    end else begin
      r_pend     <= r_pend;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps a single request outstanding to
// instruction memory, holds the fetched word until IF/ID captures it, and
// applies branch / trap redirects (discarding responses that became stale).
module if_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter logic [XLEN-1:0] INSTR_STEP = 32'h0000_0004
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            CSR_reset,
  input  logic            IFID_write,
  input  logic            dm_stall,
  input  logic            CSR_stall,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            csr_redirect,
  input  logic [XLEN-1:0] csr_target,
  output logic            im_req,
  output logic [XLEN-1:0] im_addr,
  input  logic            im_rvalid,
  input  logic [XLEN-1:0] im_rdata,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] instruction,
  output logic            im_stall,
  output logic            IFID_flush
);

  fetch_state_e    r_state, w_next_state;
  logic [XLEN-1:0] r_pc, w_pc_next;
  logic [XLEN-1:0] r_instr, w_instr_next;
  logic            r_drop, w_drop_next;
  logic            w_advance, w_im_stall, w_im_req, w_flush;
  logic [XLEN-1:0] w_im_addr, w_pc_inc;
  logic            w_set_pend, w_clr_pend;
  logic            w_redirect, w_take;
  logic [XLEN-1:0] w_redir_tgt, w_take_tgt;

  assign w_im_stall = (r_state != READY);
  assign w_advance  = IFID_write & ~w_im_stall & ~dm_stall & ~CSR_stall;
  assign w_pc_inc   = r_pc + INSTR_STEP;

  fetch_redirect_sel u_redirect_sel (
    .clk             (clk),
    .reset           (reset),
    .i_soft_rst      (CSR_reset),
    .i_csr_redirect  (csr_redirect),
    .i_csr_target    (csr_target),
    .i_branch_taken  (branch_taken),
    .i_branch_target (branch_target),
    .i_set_pend      (w_set_pend),
    .i_clr_pend      (w_clr_pend),
    .o_redirect      (w_redirect),
    .o_redir_tgt     (w_redir_tgt),
    .o_take          (w_take),
    .o_take_tgt      (w_take_tgt)
  );

  // Next-state, next-PC and request generation for the fetch FSM.
  always_comb begin
    w_next_state = r_state;
    w_pc_next    = r_pc;
    w_instr_next = r_instr;
    w_drop_next  = r_drop;
    w_im_req     = 1'b0;
    w_im_addr    = r_pc;
    w_flush      = 1'b0;
    w_set_pend   = 1'b0;
    w_clr_pend   = 1'b0;
    if (CSR_reset) begin
      w_pc_next    = RESET_PC;
      w_instr_next = NOP_INSTR;
      if ((r_state == WAIT) && !im_rvalid) begin
        // A request is still in flight: wait it out and throw it away.
        w_next_state = WAIT;
        w_drop_next  = 1'b1;
      end else begin
        w_next_state = BOOT;
        w_drop_next  = 1'b0;
      end
    end else begin
      case (r_state)
        BOOT: begin
          w_im_req     = 1'b1;
          w_im_addr    = r_pc;
          w_next_state = WAIT;
          if (w_redirect) begin
            // The request just issued targets the old PC.
            w_pc_next   = w_redir_tgt;
            w_drop_next = 1'b1;
          end else begin
            w_drop_next = 1'b0;
          end
        end
        WAIT: begin
          if (w_redirect) begin
            w_pc_next = w_redir_tgt;
            if (im_rvalid) begin
              w_drop_next  = 1'b0;
              w_next_state = BOOT;
            end else begin
              w_drop_next  = 1'b1;
            end
          end else if (im_rvalid) begin
            if (r_drop) begin
              w_drop_next  = 1'b0;
              w_next_state = BOOT;
            end else begin
              w_instr_next = im_rdata;
              w_next_state = READY;
            end
          end else begin
            w_next_state = WAIT;
          end
        end
        READY: begin
          if (w_advance) begin
            w_clr_pend   = 1'b1;
            w_im_req     = 1'b1;
            w_next_state = WAIT;
            if (w_take) begin
              w_flush   = 1'b1;
              w_pc_next = w_take_tgt;
              w_im_addr = w_take_tgt;
            end else begin
              w_pc_next = w_pc_inc;
              w_im_addr = w_pc_inc;
            end
          end else if (w_redirect) begin
            w_set_pend = 1'b1;
          end else begin
            w_next_state = READY;
          end
        end
        default: begin
          w_next_state = BOOT;
          w_drop_next  = 1'b0;
        end
      endcase
    end
  end

  // Fetch state, PC, held instruction and stale-response flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= BOOT;
      r_pc    <= RESET_PC;
      r_instr <= NOP_INSTR;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_pc    <= w_pc_next;
      r_instr <= w_instr_next;
      r_drop  <= w_drop_next;
    end
  end

  // BOOT requests immediately, so the strobe is held off while reset is low.
  assign im_req      = w_im_req & reset;
  assign im_addr     = w_im_addr;
  assign pc          = r_pc;
  assign instruction = r_instr;
  assign im_stall    = w_im_stall;
  assign IFID_flush  = w_flush;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a latency-programmable memory model.
module tb_if_fetch_unit;

  logic        clk = 1'b0, reset = 1'b0, CSR_reset = 1'b0, IFID_write = 1'b0;
  logic        dm_stall = 1'b0, CSR_stall = 1'b0, branch_taken = 1'b0, csr_redirect = 1'b0;
  logic [31:0] branch_target = 32'h0, csr_target = 32'h0;
  logic        im_req, im_rvalid, im_stall, IFID_flush;
  logic [31:0] im_addr, im_rdata, pc, instruction;

  int vectors = 0;
  int miscompares = 0;
  int lat = 1;
  logic        m_busy;
  int          m_cnt;
  logic [31:0] m_addr;
  logic [31:0] req_log[$];

  if_fetch_unit #(.RESET_PC(32'h0000_0000), .INSTR_STEP(32'h0000_0004)) dut (
    .clk(clk), .reset(reset), .CSR_reset(CSR_reset), .IFID_write(IFID_write),
    .dm_stall(dm_stall), .CSR_stall(CSR_stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .csr_redirect(csr_redirect), .csr_target(csr_target),
    .im_req(im_req), .im_addr(im_addr), .im_rvalid(im_rvalid), .im_rdata(im_rdata),
    .pc(pc), .instruction(instruction), .im_stall(im_stall), .IFID_flush(IFID_flush)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a << 8) + 32'h0000_0093;
  endfunction

  // Instruction memory: answers each request after 'lat' cycles with one rvalid pulse.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy <= 1'b0; m_cnt <= 0; m_addr <= 32'h0; im_rvalid <= 1'b0; im_rdata <= 32'h0;
    end else begin
      im_rvalid <= 1'b0;
      if (im_req) begin
        m_addr <= im_addr;
        if (lat <= 1) begin
          im_rvalid <= 1'b1; im_rdata <= mem_data(im_addr); m_busy <= 1'b0;
        end else begin
          m_busy <= 1'b1; m_cnt <= lat - 1;
        end
      end else if (m_busy) begin
        if (m_cnt == 1) begin
          im_rvalid <= 1'b1; im_rdata <= mem_data(m_addr); m_busy <= 1'b0;
        end
        m_cnt <= m_cnt - 1;
      end
    end
  end

  // Log of every issued request address.
  always @(posedge clk) begin
    if (reset && im_req) req_log.push_back(im_addr);
  end

  // Hard stop in case a test loses track of the DUT.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_reset();
    reset = 1'b0; CSR_reset = 1'b0; IFID_write = 1'b0; dm_stall = 1'b0; CSR_stall = 1'b0;
    branch_taken = 1'b0; csr_redirect = 1'b0; branch_target = 32'h0; csr_target = 32'h0;
    repeat (2) @(negedge clk);
    req_log.delete();
    reset = 1'b1;
    #1;
  endtask

  task automatic wait_ready(input int budget);
    int n = 0;
    while (im_stall === 1'b1 && n < budget) begin
      @(negedge clk); #1; n++;
    end
    vectors++; if (im_stall !== 1'b0) begin miscompares++; $display("FAIL wait_ready_timeout: im_stall got %b expected 0 within %0d cycles", im_stall, budget); end
  endtask

  task automatic test_reset();
    reset = 1'b0; IFID_write = 1'b1; branch_taken = 1'b1; branch_target = 32'h0000_0100;
    #1;
    vectors++; if (im_req !== 1'b0) begin miscompares++; $display("FAIL reset_im_req: got %b expected 0", im_req); end
    vectors++; if (pc !== 32'h0) begin miscompares++; $display("FAIL reset_pc: got %h expected 00000000", pc); end
    vectors++; if (instruction !== 32'h0) begin miscompares++; $display("FAIL reset_instr: got %h expected 00000000", instruction); end
    vectors++; if (im_stall !== 1'b1) begin miscompares++; $display("FAIL reset_im_stall: got %b expected 1", im_stall); end
    vectors++; if (IFID_flush !== 1'b0) begin miscompares++; $display("FAIL reset_flush: got %b expected 0", IFID_flush); end
    branch_taken = 1'b0; IFID_write = 1'b0;
  endtask

  task automatic test_sequential();
    logic        e_stall [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic        e_req   [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] e_addr  [7] = '{32'h0, 32'h0, 32'h4, 32'h0, 32'h8, 32'h0, 32'hC};
    logic [31:0] e_pc    [7] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h4, 32'h0, 32'h8};
    logic [31:0] e_ins   [7] = '{32'h0, 32'h0, 32'h93, 32'h0, 32'h493, 32'h0, 32'h893};
    lat = 1;
    do_reset();
    IFID_write = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      vectors++; if (im_stall !== e_stall[i]) begin miscompares++; $display("FAIL seq_stall[%0d]: got %b expected %b", i, im_stall, e_stall[i]); end
      vectors++; if (im_req !== e_req[i]) begin miscompares++; $display("FAIL seq_req[%0d]: got %b expected %b", i, im_req, e_req[i]); end
      vectors++; if (IFID_flush !== 1'b0) begin miscompares++; $display("FAIL seq_flush[%0d]: got %b expected 0", i, IFID_flush); end
      if (e_req[i]) begin
        vectors++; if (im_addr !== e_addr[i]) begin miscompares++; $display("FAIL seq_addr[%0d]: got %h expected %h", i, im_addr, e_addr[i]); end
      end
      if (!e_stall[i]) begin
        vectors++; if (pc !== e_pc[i]) begin miscompares++; $display("FAIL seq_pc[%0d]: got %h expected %h", i, pc, e_pc[i]); end
        vectors++; if (instruction !== e_ins[i]) begin miscompares++; $display("FAIL seq_instr[%0d]: got %h expected %h", i, instruction, e_ins[i]); end
      end
    end
  endtask

  task automatic test_hold();
    lat = 1;
    do_reset();
    wait_ready(10);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      vectors++; if (pc !== 32'h0 || instruction !== 32'h93) begin miscompares++; $display("FAIL hold_pair[%0d]: got %h/%h expected 00000000/00000093", i, pc, instruction); end
      vectors++; if (im_req !== 1'b0 || im_stall !== 1'b0) begin miscompares++; $display("FAIL hold_req_stall[%0d]: got %b/%b expected 0/0", i, im_req, im_stall); end
    end
    @(negedge clk); IFID_write = 1'b1; #1;
    vectors++; if (im_req !== 1'b1 || im_addr !== 32'h4) begin miscompares++; $display("FAIL hold_release: got req %b addr %h expected 1 00000004", im_req, im_addr); end
    vectors++; if (req_log.size() != 1) begin miscompares++; $display("FAIL hold_req_count: got %0d expected 1", req_log.size()); end
  endtask

  task automatic test_branch_ready();
    lat = 1;
    do_reset();
    wait_ready(10);
    @(negedge clk); branch_taken = 1'b1; branch_target = 32'h0000_0100; IFID_write = 1'b1; #1;
    vectors++; if (IFID_flush !== 1'b1) begin miscompares++; $display("FAIL br_flush: got %b expected 1", IFID_flush); end
    vectors++; if (im_req !== 1'b1 || im_addr !== 32'h100) begin miscompares++; $display("FAIL br_addr: got req %b addr %h expected 1 00000100", im_req, im_addr); end
    @(negedge clk); branch_taken = 1'b0; IFID_write = 1'b0; #1;
    wait_ready(10);
    vectors++; if (pc !== 32'h100 || instruction !== 32'h0001_0093) begin miscompares++; $display("FAIL br_target_pair: got %h/%h expected 00000100/00010093", pc, instruction); end
  endtask

  task automatic test_wrap();
    lat = 1;
    do_reset();
    wait_ready(10);
    @(negedge clk); branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC; IFID_write = 1'b1; #1;
    @(negedge clk); branch_taken = 1'b0; IFID_write = 1'b0; #1;
    wait_ready(10);
    vectors++; if (pc !== 32'hFFFF_FFFC || instruction !== 32'hFFFF_FC93) begin miscompares++; $display("FAIL wrap_pair: got %h/%h expected fffffffc/fffffc93", pc, instruction); end
    @(negedge clk); IFID_write = 1'b1; #1;
    vectors++; if (im_req !== 1'b1 || im_addr !== 32'h0 || IFID_flush !== 1'b0) begin miscompares++; $display("FAIL wrap_addr: got req %b addr %h flush %b expected 1 00000000 0", im_req, im_addr, IFID_flush); end
  endtask

  task automatic test_branch_wait();
    lat = 4;
    do_reset();
    @(negedge clk); branch_taken = 1'b1; branch_target = 32'h0000_0200; #1;
    vectors++; if (im_stall !== 1'b1 || im_req !== 1'b0 || IFID_flush !== 1'b0) begin miscompares++; $display("FAIL bw_wait_outputs: got stall %b req %b flush %b expected 1 0 0", im_stall, im_req, IFID_flush); end
    @(negedge clk); branch_taken = 1'b0; #1;
    wait_ready(30);
    vectors++; if (pc !== 32'h200 || instruction !== 32'h0002_0093) begin miscompares++; $display("FAIL bw_pair: got %h/%h expected 00000200/00020093", pc, instruction); end
    vectors++; if (req_log.size() != 2) begin miscompares++; $display("FAIL bw_req_count: got %0d expected 2", req_log.size()); end
    else begin
      vectors++; if (req_log[1] !== 32'h200) begin miscompares++; $display("FAIL bw_refetch_addr: got %h expected 00000200", req_log[1]); end
    end
  endtask

  task automatic test_pend();
    lat = 1;
    do_reset();
    IFID_write = 1'b1; dm_stall = 1'b1;
    wait_ready(10);
    @(negedge clk); csr_redirect = 1'b1; csr_target = 32'h80; branch_taken = 1'b1; branch_target = 32'h40; #1;
    vectors++; if (IFID_flush !== 1'b0 || im_req !== 1'b0) begin miscompares++; $display("FAIL pend_hold: got flush %b req %b expected 0 0", IFID_flush, im_req); end
    @(negedge clk); csr_redirect = 1'b0; branch_taken = 1'b0; #1;
    vectors++; if (im_req !== 1'b0 || pc !== 32'h0 || im_stall !== 1'b0) begin miscompares++; $display("FAIL pend_idle: got req %b pc %h stall %b expected 0 00000000 0", im_req, pc, im_stall); end
    @(negedge clk); dm_stall = 1'b0; #1;
    vectors++; if (IFID_flush !== 1'b1 || im_req !== 1'b1 || im_addr !== 32'h80) begin miscompares++; $display("FAIL pend_apply: got flush %b req %b addr %h expected 1 1 00000080", IFID_flush, im_req, im_addr); end
    @(negedge clk); IFID_write = 1'b0; #1;
    wait_ready(10);
    vectors++; if (pc !== 32'h80 || instruction !== 32'h0000_8093) begin miscompares++; $display("FAIL pend_pair: got %h/%h expected 00000080/00008093", pc, instruction); end
  endtask

  task automatic test_csr_reset_wait();
    int n = 0;
    lat = 4;
    do_reset();
    wait_ready(20);
    @(negedge clk); IFID_write = 1'b1; #1;
    @(negedge clk); IFID_write = 1'b0; CSR_reset = 1'b1; #1;
    vectors++; if (im_req !== 1'b0) begin miscompares++; $display("FAIL csrr_req: got %b expected 0", im_req); end
    @(negedge clk); CSR_reset = 1'b0; #1;
    vectors++; if (pc !== 32'h0 || instruction !== 32'h0 || im_stall !== 1'b1) begin miscompares++; $display("FAIL csrr_cleared: got pc %h instr %h stall %b expected 00000000 00000000 1", pc, instruction, im_stall); end
    while (n < 20) begin
      @(negedge clk); #1; n++;
      if (im_req === 1'b1) break;
    end
    vectors++; if (n != 3 || im_addr !== 32'h0) begin miscompares++; $display("FAIL csrr_refetch: got %0d cycles addr %h expected 3 cycles 00000000", n, im_addr); end
    vectors++; if (instruction !== 32'h0) begin miscompares++; $display("FAIL csrr_stale: got %h expected 00000000", instruction); end
    wait_ready(20);
    vectors++; if (pc !== 32'h0 || instruction !== 32'h93) begin miscompares++; $display("FAIL csrr_pair: got %h/%h expected 00000000/00000093", pc, instruction); end
  endtask

  task automatic test_async_reset();
    lat = 4;
    do_reset();
    wait_ready(20);
    @(negedge clk); IFID_write = 1'b1; #1;
    @(negedge clk); IFID_write = 1'b0; #2;
    vectors++; if (pc !== 32'h4 || im_stall !== 1'b1) begin miscompares++; $display("FAIL ar_pre: got pc %h stall %b expected 00000004 1", pc, im_stall); end
    reset = 1'b0; #1;
    vectors++; if (im_req !== 1'b0 || pc !== 32'h0 || instruction !== 32'h0) begin miscompares++; $display("FAIL ar_outputs: got req %b pc %h instr %h expected 0 00000000 00000000", im_req, pc, instruction); end
    vectors++; if (im_stall !== 1'b1 || IFID_flush !== 1'b0) begin miscompares++; $display("FAIL ar_flags: got stall %b flush %b expected 1 0", im_stall, IFID_flush); end
  endtask

  // Scenario sequence and summary.
  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    test_sequential();
    test_hold();
    test_branch_ready();
    test_wrap();
    test_branch_wait();
    test_pend();
    test_csr_reset_wait();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch stage that produces the pc/instruction pair consumed by the IF/ID pipeline register. It owns the program counter and issues single-outstanding requests to instruction memory. It holds each fetched word until the IF/ID register captures it, and applies branch and CSR (trap/mret) redirects. It generates im_stall and IFID_flush for the downstream stage.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset and on CSR_reset
INSTR_STEP, 4, PC increment per sequential fetch

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-low reset
CSR_reset  in  1  synchronous soft reset from CSR unit, active-high
IFID_write  in  1  hazard unit permits IF/ID update
dm_stall  in  1  data memory stall
CSR_stall  in  1  CSR unit stall
branch_taken  in  1  redirect request from EX
branch_target  in  32  branch/jump target
csr_redirect  in  1  trap/mret redirect request
csr_target  in  32  trap vector or mepc
im_req  out  1  instruction memory request strobe, one cycle per request
im_addr  out  32  request address, valid with im_req
im_rvalid  in  1  instruction memory response valid
im_rdata  in  32  response data
pc  out  32  PC of the held instruction
instruction  out  32  held instruction word
im_stall  out  1  no valid instruction available
IFID_flush  out  1  zero the instruction captured by IF/ID this cycle

Behaviour:
- Reset: clk, reset (asynchronous, active-low).
- reset low, asynchronously:
  - state=BOOT, pc_q=RESET_PC, instr_q=0, pend=0, drop=0.
  - Outputs: im_req=0, pc=RESET_PC, instruction=0, im_stall=1, IFID_flush=0.
- advance = IFID_write & ~im_stall & ~dm_stall & ~CSR_stall. This is exactly the condition under which IF/ID captures.
- Redirect priority: csr_redirect > branch_taken. redir_tgt is the winning target.
- BOOT:
  - im_req=1, im_addr=pc_q; go WAIT.
  - im_stall=1.
- WAIT:
  - im_stall=1, im_req=0.
  - On im_rvalid with drop=0: instr_q<=im_rdata; go READY.
  - On im_rvalid with drop=1: discard the data; drop<=0; go BOOT (refetch at pc_q).
  - Redirect in WAIT: pc_q<=redir_tgt and drop<=1. If im_rvalid arrives the same cycle, that data is discarded and the next state is BOOT.
- READY:
  - im_stall=0; pc=pc_q, instruction=instr_q.
  - advance without redirect or pend: pc_q<=pc_q+INSTR_STEP; im_req=1, im_addr=pc_q+INSTR_STEP in the same cycle; go WAIT.
  - advance with redirect (or pend=1): IFID_flush=1; pc_q<=redir_tgt (or the pended target); im_req=1, im_addr=target; pend<=0; go WAIT.
  - Redirect without advance: pend<=1 and pend_tgt<=redir_tgt. A later redirect overwrites pend_tgt. The redirect is applied on the next advance.
- IFID_flush is asserted only together with advance in READY. It is never asserted in BOOT or WAIT, because im_stall blocks capture there.
- Only one memory request is ever outstanding. im_req is never asserted while in WAIT.
- CSR_reset (synchronous) overrides every other input:
  - pc_q<=RESET_PC, instr_q<=0, pend<=0.
  - State goes to BOOT.
  - If CSR_reset is taken in WAIT, drop<=1 so the stale response is discarded. In that case the unit stays in WAIT until the response returns, then goes to BOOT.
- PC arithmetic is 32-bit modulo. 32'hFFFF_FFFC + 4 wraps to 0.
- Memory latency: at least 1 cycle after im_req, unbounded. Best-case throughput is one instruction per 2 cycles.

Decomposition:
- Shared package cpu_pkg:
  - fetch_state_e enum {BOOT, WAIT, READY}
  - NOP_INSTR constant 32'h0
  - XLEN=32
- Sub-module fetch_redirect_sel (combinational priority select plus pend/pend_tgt register). The next-PC logic stays in the top module.

Test Plan:
- Reset release, memory returns 32'h00000093 at 1-cycle latency, IFID_write=1 -> im_addr sequence 0x0, 0x4, 0x8; pc/instruction valid in alternate cycles; im_stall=1 during WAIT.
- READY with IFID_write=0 for 5 cycles -> pc and instruction stable, im_req=0, no new address issued; the next request goes to pc+4 once IFID_write=1.
- branch_taken target 0x100 in READY with advance -> IFID_flush=1 that cycle, im_addr=0x100; the next held instruction has pc=0x100.
- branch_taken target 0x200 during WAIT (4-cycle latency) -> stale response dropped, instruction never updated with it, refetch at 0x200.
- csr_redirect 0x80 and branch_taken 0x40 in the same cycle while dm_stall=1 -> pend holds 0x80; after dm_stall falls, im_addr=0x80 with IFID_flush=1.
- CSR_reset during WAIT -> late response discarded, refetch at RESET_PC; async reset asserted mid-WAIT -> all outputs return to their reset values immediately.
